// File: rtl/sound_pkg.sv
// Shared types and the effect descriptor table for the sound effect engine.
// Table order is also priority order: a higher index wins.
package sound_pkg;

    localparam int SFX_NUM     = 4;
    localparam int SFX_DIV_W   = 4;
    localparam int SFX_PHASE_W = 5;
    localparam int SFX_ID_W    = (SFX_NUM > 1) ? $clog2(SFX_NUM) : 1;

    typedef enum logic [2:0] {
        FLAT,
        RAMP_UP,
        RAMP_DOWN,
        PEAK,
        BEEP
    } shape_e;

    // A len of 0 encodes the full 2^SFX_PHASE_W frames.
    typedef struct packed {
        logic [SFX_DIV_W-1:0]   div0;
        logic [SFX_PHASE_W-1:0] len;
        shape_e                 shape;
    } sfx_desc_t;

    localparam sfx_desc_t SFX_TABLE [SFX_NUM] = '{
        '{div0: 4'd5, len: 5'd2,  shape: FLAT},
        '{div0: 4'd3, len: 5'd24, shape: PEAK},
        '{div0: 4'd3, len: 5'd24, shape: BEEP},
        '{div0: 4'd9, len: 5'd24, shape: BEEP}
    };

    function automatic logic [SFX_ID_W-1:0] sfx_winner(input logic [SFX_NUM-1:0] req);
        sfx_winner = '0;
        for (int i = 0; i < SFX_NUM; i++) begin
            if (req[i]) sfx_winner = SFX_ID_W'(i);
        end
    endfunction

endpackage

// File: rtl/sound_sfx_engine_if.sv
// Game-side connection of the sound effect engine: event strobes and timing
// inputs from the master, the audio line and status back from the engine.
interface sound_sfx_engine_if #(
    parameter int NUM_SFX = 4,
    parameter int ID_W    = 2
);
    logic               vsync;
    logic               pwm_base;
    logic               mute;
    logic [NUM_SFX-1:0] sfx_req;
    logic               audio;
    logic               busy;
    logic [ID_W-1:0]    active_id;

    modport master (
        output vsync, pwm_base, mute, sfx_req,
        input  audio, busy, active_id
    );

    modport slave (
        input  vsync, pwm_base, mute, sfx_req,
        output audio, busy, active_id
    );
endinterface

// File: rtl/sound_tone.sv
// Square-wave tone generator: half-period of (div+1) steps, synchronous clear.
// The >= compare lets a shrinking div take effect without a long wrap.
module sound_tone #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [DIV_W-1:0] div,
    output logic             tone
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tone_q, tone_d;

    always_comb begin
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (clr) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (step) begin
            if (cnt_q >= div) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;
endmodule

// File: rtl/sound_sfx_engine.sv
// Prioritised one-shot sound effect engine driving a 1-bit square-wave line.
// Optional SOUND_SFX_QUEUE_EN adds one pending slot for outranked requests.
//   state   | meaning
//   ST_IDLE | silent, any request is accepted
//   ST_PLAY | effect active_id playing; equal/higher requests restart/preempt
module sound_sfx_engine
    import sound_pkg::*;
#(
    parameter int NUM_SFX = SFX_NUM,
    parameter int DIV_W   = SFX_DIV_W,
    parameter int PHASE_W = SFX_PHASE_W
) (
    input logic                clk,
    input logic                rst,
    sound_sfx_engine_if.slave  sif
);
    localparam int ID_W = (NUM_SFX > 1) ? $clog2(NUM_SFX) : 1;

    typedef enum logic {ST_IDLE, ST_PLAY} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               audio_q, audio_d;
    logic               prev_vsync_q, prev_pwm_q;

    logic               busy, pwm_edge, frame_edge, tone;
    logic               any_req, accept, reject, last_frame, start, start_pend;
    logic [ID_W-1:0]    win, start_id;
    shape_e             cur_shape;
    logic [PHASE_W-1:0] cur_len;
    logic [PHASE_W:0]   len_full, half_len;
    logic [PHASE_W-1:0] phase_inc;
    logic [DIV_W-1:0]   div_inc, div_dec;

    assign busy       = (state_q == ST_PLAY);
    assign pwm_edge   = sif.pwm_base & ~prev_pwm_q;
    assign frame_edge = sif.vsync & ~prev_vsync_q;

    assign win     = sfx_winner(sif.sfx_req);
    assign any_req = |sif.sfx_req;
    assign accept  = any_req && (!busy || win >= id_q);
    assign reject  = any_req && !accept;

    assign cur_shape  = SFX_TABLE[id_q].shape;
    assign cur_len    = PHASE_W'(SFX_TABLE[id_q].len);
    assign len_full   = {(cur_len == '0), cur_len};
    assign half_len   = len_full >> 1;
    assign phase_inc  = phase_q + 1'b1;
    assign div_inc    = (div_q != '1) ? div_q + 1'b1 : div_q;
    assign div_dec    = (div_q != '0) ? div_q - 1'b1 : div_q;
    assign last_frame = busy && frame_edge && (phase_q == cur_len - 1'b1);
    assign start      = accept || start_pend;

`ifdef SOUND_SFX_QUEUE_EN
    logic            pend_v_q, pend_v_d;
    logic [ID_W-1:0] pend_id_q, pend_id_d;

    assign start_pend = last_frame && !accept && pend_v_q;
    assign start_id   = accept ? win : pend_id_q;

    always_comb begin
        pend_v_d  = pend_v_q;
        pend_id_d = pend_id_q;
        if (start_pend) pend_v_d = 1'b0;
        if (accept && win >= pend_id_q) pend_v_d = 1'b0;
        if (reject && (!pend_v_d || win > pend_id_q)) begin
            pend_v_d  = 1'b1;
            pend_id_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q  <= 1'b0;
            pend_id_q <= '0;
        end else begin
            pend_v_q  <= pend_v_d;
            pend_id_q <= pend_id_d;
        end
    end
`else
    assign start_pend = 1'b0;
    assign start_id   = win;
`endif

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        div_d   = div_q;
        phase_d = phase_q;
        if (start) begin
            state_d = ST_PLAY;
            id_d    = start_id;
            div_d   = DIV_W'(SFX_TABLE[start_id].div0);
            phase_d = '0;
        end else if (busy && frame_edge) begin
            phase_d = phase_inc;
            // PEAK turns around at half length, judged on the advanced phase.
            case (cur_shape)
                RAMP_UP:   div_d = div_inc;
                RAMP_DOWN: div_d = div_dec;
                PEAK:      div_d = ({1'b0, phase_inc} < half_len) ? div_inc : div_dec;
                default:   div_d = div_q;
            endcase
            if (last_frame) state_d = ST_IDLE;
        end
        audio_d = busy & tone & ~sif.mute & ~((cur_shape == BEEP) & phase_q[2]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            id_q         <= '0;
            div_q        <= '0;
            phase_q      <= '0;
            audio_q      <= 1'b0;
            prev_vsync_q <= 1'b0;
            prev_pwm_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            audio_q      <= audio_d;
            prev_vsync_q <= sif.vsync;
            prev_pwm_q   <= sif.pwm_base;
        end
    end

    sound_tone #(.DIV_W(DIV_W)) u_tone (
        .clk  (clk),
        .rst  (rst),
        .clr  (start),
        .step (pwm_edge & busy),
        .div  (div_q),
        .tone (tone)
    );

    assign sif.audio     = audio_q;
    assign sif.busy      = busy;
    assign sif.active_id = id_q;
endmodule
